// File: rtl/ac_climate_ctrl_if.sv
// rtl/ac_climate_ctrl_if.sv - setpoint controls and temperature/status outputs of the climate controller
interface ac_climate_ctrl_if #(
   parameter int TEMP_W = 3
);
   logic              inc;
   logic              dec;
   logic              set_valid;
   logic [TEMP_W-1:0] set_value;
   logic [TEMP_W-1:0] temp_target;
   logic [TEMP_W-1:0] temp_actual;
   logic              heating;
   logic              cooling;
   logic              at_target;
   logic              drip;

   modport master (
      output inc, dec, set_valid, set_value,
      input  temp_target, temp_actual, heating, cooling, at_target, drip
   );

   modport slave (
      input  inc, dec, set_valid, set_value,
      output temp_target, temp_actual, heating, cooling, at_target, drip
   );
endinterface

// File: rtl/ac_climate_ctrl.sv
// rtl/ac_climate_ctrl.sv - setpoint tracker stepping actual temperature toward target, with drip indicator
module ac_climate_ctrl #(
   parameter int TEMP_W      = 3,
   parameter int STEP_CYCLES = 2,
   parameter int DRIP_DELAY  = 10,
   parameter int DRIP_CLEAR  = 3
) (
   input  logic              clk_2,
   input  logic              reset_n,
   ac_climate_ctrl_if.slave  bus
);
   localparam int STEP_W = $clog2(STEP_CYCLES + 1);
   localparam int DRIP_W = $clog2(DRIP_DELAY + 1);
   localparam int CLR_W  = $clog2(DRIP_CLEAR + 1);

   localparam logic [TEMP_W-1:0] TEMP_MAX  = {TEMP_W{1'b1}};
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [DRIP_W-1:0] DRIP_LIM  = DRIP_W'(DRIP_DELAY);
   localparam logic [DRIP_W-1:0] DRIP_LAST = DRIP_W'(DRIP_DELAY - 1);
   localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(DRIP_CLEAR - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEATING = 2'd1,
      COOLING = 2'd2
   } state_t;

   state_t              state_q;
   logic [TEMP_W-1:0]   target_q;
   logic [TEMP_W-1:0]   target_d;
   logic [TEMP_W-1:0]   actual_q;
   logic [STEP_W-1:0]   step_cnt_q;
   logic [DRIP_W-1:0]   drip_cnt_q;
   logic [CLR_W-1:0]    clear_cnt_q;
   logic                drip_q;
   logic                drip_done_q;
   logic                clear_cond;

   // Direct load beats inc/dec; opposing requests cancel; both ends saturate.
   always_comb begin
      target_d = target_q;
      if (bus.set_valid) begin
         target_d = bus.set_value;
      end else if (bus.inc && !bus.dec) begin
         if (target_q < TEMP_MAX) target_d = target_q + 1'b1;
      end else if (bus.dec && !bus.inc) begin
         if (target_q > '0) target_d = target_q - 1'b1;
      end
   end

   assign clear_cond = drip_q && (state_q == IDLE) && (actual_q == TEMP_MAX);

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         target_q    <= '0;
         actual_q    <= '0;
         step_cnt_q  <= '0;
         drip_cnt_q  <= '0;
         clear_cnt_q <= '0;
         drip_q      <= 1'b0;
         drip_done_q <= 1'b0;
      end else begin
         target_q <= target_d;

         // The FSM deliberately compares against the pre-update setpoint.
         case (state_q)
            IDLE: begin
               if (target_q > actual_q) begin
                  state_q    <= HEATING;
                  step_cnt_q <= '0;
               end else if (target_q < actual_q) begin
                  state_q    <= COOLING;
                  step_cnt_q <= '0;
               end
            end
            HEATING: begin
               if (actual_q >= target_q) begin
                  state_q <= IDLE;
               end else if (step_cnt_q == STEP_LAST) begin
                  actual_q   <= actual_q + 1'b1;
                  step_cnt_q <= '0;
               end else begin
                  step_cnt_q <= step_cnt_q + 1'b1;
               end
            end
            COOLING: begin
               if (actual_q <= target_q) begin
                  state_q <= IDLE;
               end else if (step_cnt_q == STEP_LAST) begin
                  actual_q   <= actual_q - 1'b1;
                  step_cnt_q <= '0;
               end else begin
                  step_cnt_q <= step_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (drip_cnt_q < DRIP_LIM) drip_cnt_q <= drip_cnt_q + 1'b1;
         if ((drip_cnt_q == DRIP_LAST) && !drip_done_q) drip_q <= 1'b1;

         // Placed after the assertion so a coincident clear takes precedence.
         if (clear_cond) begin
            clear_cnt_q <= clear_cnt_q + 1'b1;
            if (clear_cnt_q == CLR_LAST) begin
               drip_q      <= 1'b0;
               drip_done_q <= 1'b1;
            end
         end else begin
            clear_cnt_q <= '0;
         end
      end
   end

   assign bus.temp_target = target_q;
   assign bus.temp_actual = actual_q;
   assign bus.heating     = (state_q == HEATING);
   assign bus.cooling     = (state_q == COOLING);
   assign bus.at_target   = (state_q == IDLE) && (actual_q == target_q);
   assign bus.drip        = drip_q;
endmodule

// File: tb/tb_ac_climate_ctrl.sv
// tb/tb_ac_climate_ctrl.sv - self-checking bench for ac_climate_ctrl
module tb_ac_climate_ctrl;
   localparam int TEMP_W      = 3;
   localparam int STEP_CYCLES = 2;
   localparam int DRIP_DELAY  = 10;
   localparam int DRIP_CLEAR  = 3;
   localparam int TMAX        = (1 << TEMP_W) - 1;
   localparam int VW          = 2 * TEMP_W + 4;
   localparam logic [VW-1:0] RESET_VEC = {3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0};

   logic clk_2   = 1'b0;
   logic reset_n = 1'b0;
   int   errors  = 0;
   int   checks  = 0;

   ac_climate_ctrl_if #(.TEMP_W(TEMP_W)) ifc ();

   ac_climate_ctrl #(
      .TEMP_W(TEMP_W), .STEP_CYCLES(STEP_CYCLES),
      .DRIP_DELAY(DRIP_DELAY), .DRIP_CLEAR(DRIP_CLEAR)
   ) dut (
      .clk_2(clk_2),
      .reset_n(reset_n),
      .bus(ifc.slave)
   );

   always #5 clk_2 = ~clk_2;

   // Reference: direction is +1/-1/0, motion one unit per STEP_CYCLES while moving.
   int m_tgt, m_act, m_dir, m_cnt, m_age, m_clr;
   bit m_drip, m_done;

   task automatic model_reset();
      m_tgt = 0; m_act = 0; m_dir = 0; m_cnt = 0;
      m_age = 0; m_clr = 0; m_drip = 0; m_done = 0;
   endtask

   task automatic model_step();
      int t0, a0, d0, age0, clr0;
      bit drip0;
      t0 = m_tgt; a0 = m_act; d0 = m_dir; age0 = m_age; clr0 = m_clr; drip0 = m_drip;
      if (d0 == 0) begin
         if (t0 != a0) begin
            m_dir = (t0 > a0) ? 1 : -1;
            m_cnt = 0;
         end
      end else if ((a0 - t0) * d0 >= 0) begin
         m_dir = 0;
      end else if (m_cnt == STEP_CYCLES - 1) begin
         m_act = a0 + d0;
         m_cnt = 0;
      end else begin
         m_cnt = m_cnt + 1;
      end
      if (age0 < DRIP_DELAY) m_age = age0 + 1;
      if (age0 == DRIP_DELAY - 1 && !m_done) m_drip = 1;
      if (drip0 && d0 == 0 && a0 == TMAX) begin
         if (clr0 == DRIP_CLEAR - 1) begin
            m_drip = 0;
            m_done = 1;
         end
         m_clr = clr0 + 1;
      end else begin
         m_clr = 0;
      end
      if (ifc.set_valid) m_tgt = int'(ifc.set_value);
      else if (ifc.inc && !ifc.dec) m_tgt = (t0 < TMAX) ? t0 + 1 : t0;
      else if (ifc.dec && !ifc.inc) m_tgt = (t0 > 0) ? t0 - 1 : t0;
   endtask

   function automatic logic [VW-1:0] exp_vec();
      return {TEMP_W'(m_tgt), TEMP_W'(m_act), m_dir == 1, m_dir == -1,
              (m_dir == 0) && (m_act == m_tgt), m_drip};
   endfunction

   function automatic logic [VW-1:0] got_vec();
      return {ifc.temp_target, ifc.temp_actual, ifc.heating, ifc.cooling,
              ifc.at_target, ifc.drip};
   endfunction

   task automatic tick();
      @(posedge clk_2);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      ifc.inc = 1'b0; ifc.dec = 1'b0; ifc.set_valid = 1'b0; ifc.set_value = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      #2;
      model_reset();
      reset_n = 1'b1;
   endtask

   task automatic set_target(input int v);
      ifc.set_valid = 1'b1;
      ifc.set_value = TEMP_W'(v);
      tick();
      ifc.set_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (got_vec() !== RESET_VEC) begin
         errors++;
         $display("FAIL reset_state: got %b expected %b", got_vec(), RESET_VEC);
      end
   endtask

   task automatic test_inc_latency();
      int exp_act[5]  = '{0, 0, 0, 1, 1};
      bit exp_heat[5] = '{0, 1, 1, 1, 0};
      bit exp_at[5]   = '{0, 0, 0, 0, 1};
      do_reset();
      ifc.inc = 1'b1;
      for (int e = 0; e < 5; e++) begin
         tick();
         ifc.inc = 1'b0;
         checks++;
         if (ifc.temp_target !== 3'd1 || ifc.temp_actual !== TEMP_W'(exp_act[e]) ||
             ifc.heating !== exp_heat[e] || ifc.at_target !== exp_at[e]) begin
            errors++;
            $display("FAIL inc_latency edge %0d: got tgt=%0d act=%0d heat=%b at=%b expected tgt=1 act=%0d heat=%b at=%b",
                     e, ifc.temp_target, ifc.temp_actual, ifc.heating, ifc.at_target,
                     exp_act[e], exp_heat[e], exp_at[e]);
         end
      end
   endtask

   task automatic test_set_load();
      int n_act, n_at, n_heat;
      do_reset();
      set_target(5);
      n_act = -1; n_at = -1; n_heat = 0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (ifc.heating) n_heat++;
         if (n_act < 0 && ifc.temp_actual == 3'd5) n_act = e;
         if (n_at < 0 && ifc.at_target) n_at = e;
      end
      checks++;
      if (ifc.temp_target !== 3'd5) begin
         errors++;
         $display("FAIL set_load_target: got %0d expected 5", ifc.temp_target);
      end
      checks++;
      if (n_act != 11 || n_at != 12 || n_heat != 11) begin
         errors++;
         $display("FAIL set_load_timing: got act_edge=%0d at_edge=%0d heat_cycles=%0d expected 11 12 11",
                  n_act, n_at, n_heat);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      set_target(7);
      ifc.inc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (ifc.temp_target !== 3'd7) begin
            errors++;
            $display("FAIL sat_high: got %0d expected 7", ifc.temp_target);
         end
      end
      ifc.inc = 1'b0;
      set_target(0);
      ifc.dec = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (ifc.temp_target !== 3'd0) begin
            errors++;
            $display("FAIL sat_low: got %0d expected 0", ifc.temp_target);
         end
      end
      set_target(4);
      ifc.inc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (ifc.temp_target !== 3'd4) begin
            errors++;
            $display("FAIL inc_and_dec: got %0d expected 4", ifc.temp_target);
         end
      end
      ifc.dec = 1'b0;
      tick();
      ifc.inc = 1'b0;
      checks++;
      if (ifc.temp_target !== 3'd5) begin
         errors++;
         $display("FAIL inc_single: got %0d expected 5", ifc.temp_target);
      end
      ifc.dec = 1'b1;
      tick();
      ifc.dec = 1'b0;
      checks++;
      if (ifc.temp_target !== 3'd4) begin
         errors++;
         $display("FAIL dec_single: got %0d expected 4", ifc.temp_target);
      end
   endtask

   task automatic test_retarget();
      int n, max_act;
      do_reset();
      set_target(6);
      for (int i = 0; i < 30 && ifc.temp_actual != 3'd4; i++) tick();
      checks++;
      if (ifc.temp_actual !== 3'd4) begin
         errors++;
         $display("FAIL retarget_climb: got act=%0d expected 4", ifc.temp_actual);
      end
      set_target(2);
      checks++;
      if (ifc.heating !== 1'b1 || ifc.temp_actual !== 3'd4) begin
         errors++;
         $display("FAIL retarget_still_heating: got heat=%b act=%0d expected 1 4", ifc.heating, ifc.temp_actual);
      end
      tick();
      checks++;
      if ({ifc.heating, ifc.cooling, ifc.at_target} !== 3'b000 || ifc.temp_actual !== 3'd4) begin
         errors++;
         $display("FAIL retarget_idle_gap: got h/c/at=%b act=%0d expected 000 4",
                  {ifc.heating, ifc.cooling, ifc.at_target}, ifc.temp_actual);
      end
      tick();
      checks++;
      if (ifc.cooling !== 1'b1) begin
         errors++;
         $display("FAIL retarget_cooling: got %b expected 1", ifc.cooling);
      end
      n = -1; max_act = 0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (int'(ifc.temp_actual) > max_act) max_act = int'(ifc.temp_actual);
         if (n < 0 && ifc.temp_actual == 3'd2) n = e;
      end
      checks++;
      if (n != 4 || max_act != 4) begin
         errors++;
         $display("FAIL retarget_descent: got edges=%0d max=%0d expected 4 4", n, max_act);
      end
   endtask

   task automatic test_drip();
      int bad;
      do_reset();
      for (int e = 1; e <= 12; e++) begin
         tick();
         checks++;
         if (ifc.drip !== (e >= DRIP_DELAY)) begin
            errors++;
            $display("FAIL drip_assert edge %0d: got %b expected %b", e, ifc.drip, e >= DRIP_DELAY);
         end
      end
      set_target(7);
      for (int i = 0; i < 40 && !(ifc.at_target && ifc.temp_actual == 3'd7); i++) tick();
      tick();
      tick();
      checks++;
      if (ifc.drip !== 1'b1 || ifc.temp_actual !== 3'd7) begin
         errors++;
         $display("FAIL drip_hold_before_clear: got drip=%b act=%0d expected 1 7", ifc.drip, ifc.temp_actual);
      end
      tick();
      checks++;
      if (ifc.drip !== 1'b0) begin
         errors++;
         $display("FAIL drip_clear: got %b expected 0", ifc.drip);
      end
      bad = 0;
      set_target(3);
      for (int i = 0; i < 20; i++) begin tick(); if (ifc.drip !== 1'b0) bad++; end
      set_target(7);
      for (int i = 0; i < 25; i++) begin tick(); if (ifc.drip !== 1'b0) bad++; end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL drip_stays_clear: got %0d cycles high expected 0", bad);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_target(7);
      for (int i = 0; i < 40 && !ifc.at_target; i++) tick();
      set_target(0);
      for (int i = 0; i < 20 && !(ifc.cooling && ifc.temp_actual < 3'd6); i++) tick();
      checks++;
      if (!(ifc.cooling && ifc.temp_actual < 3'd6)) begin
         errors++;
         $display("FAIL async_setup: got cool=%b act=%0d expected cooling below 6", ifc.cooling, ifc.temp_actual);
      end
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (got_vec() !== RESET_VEC) begin
         errors++;
         $display("FAIL async_reset: got %b expected %b", got_vec(), RESET_VEC);
      end
      #1;
      model_reset();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL async_after: got %b expected %b", got_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      int shown = 0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         ifc.set_valid = ($urandom_range(0, 11) == 0);
         ifc.set_value = TEMP_W'($urandom);
         ifc.inc       = ($urandom_range(0, 5) == 0);
         ifc.dec       = ($urandom_range(0, 5) == 0);
         tick();
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            if (shown < 10) begin
               shown++;
               $display("FAIL random cycle %0d: got %b expected %b", c, got_vec(), exp_vec());
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_inc_latency();
      test_set_load();
      test_saturation();
      test_retarget();
      test_drip();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
